// File: rtl/data_mem_responder.sv
// data_mem_responder: 128 x 32-bit data memory shared by a CPU port (SRAM-style,
// active-low controls) and a host/loader port that only gets a slot on cycles
// the CPU leaves free. Counts CPU reads and writes with saturating counters.
//
// Host handshake: host_ready is simply the inverse of CPU activity (CEN high).
// A host request is performed on a rising edge where host_valid and host_ready
// are both high; the requester keeps the request stable until that edge. A read
// returns data on host_rdata with a one-cycle host_rvalid pulse after the edge.
module data_mem_responder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             CEN,
    input  logic             WEN,
    input  logic [6:0]       A,
    input  logic [31:0]      D,
    input  logic             OEN,
    output logic [31:0]      Q,
    input  logic             host_valid,
    input  logic             host_we,
    input  logic [6:0]       host_addr,
    input  logic [31:0]      host_wdata,
    output logic             host_ready,
    output logic             host_rvalid,
    output logic [31:0]      host_rdata,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Storage is deliberately not reset: contents survive rst_n.
    logic [31:0] mem [128];

    logic             cpu_rd;
    logic             cpu_wr;
    logic             host_acc;
    logic             host_rd;
    logic             mem_we;
    logic [6:0]       mem_waddr;
    logic [31:0]      mem_wdata;

    logic [31:0]      cpu_rdata_q;
    logic [31:0]      host_rdata_q;
    logic             host_rvalid_q;
    logic [CNT_W-1:0] rd_cnt_q;
    logic [CNT_W-1:0] rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q;
    logic [CNT_W-1:0] wr_cnt_d;

    // Decode who owns the single memory slot this cycle; the CPU always wins.
    always_comb begin
        cpu_rd    = ~CEN & WEN;
        cpu_wr    = ~CEN & ~WEN;
        host_acc  = host_valid & CEN;
        host_rd   = host_acc & ~host_we;
        mem_we    = cpu_wr | (host_acc & host_we);
        mem_waddr = cpu_wr ? A : host_addr;
        mem_wdata = cpu_wr ? D : host_wdata;
    end

    // Saturating next-state values for the access counters.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (cpu_rd && (rd_cnt_q != CNT_MAX)) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (cpu_wr && (wr_cnt_q != CNT_MAX)) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    // Memory write port; edges taken while in reset are ignored, contents kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // hold contents
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read registers, host read-valid pulse and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata_q   <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
        end else begin
            host_rvalid_q <= host_rd;
            if (cpu_rd) begin
                cpu_rdata_q <= mem[A];
            end
            if (host_rd) begin
                host_rdata_q <= mem[host_addr];
            end
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Output enable only masks the data bus; it never gates the access.
    always_comb begin
        Q           = OEN ? 32'h0 : cpu_rdata_q;
        host_ready  = CEN;
        host_rvalid = host_rvalid_q;
        host_rdata  = host_rdata_q;
        rd_cnt      = rd_cnt_q;
        wr_cnt      = wr_cnt_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, multi-cycle corner
// sequences (counter saturation, reset during an in-flight host read, requests
// during reset) and random traffic checked against a behavioural model.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        CEN, WEN, OEN;
    logic [6:0]  A;
    logic [31:0] D;
    logic        host_valid, host_we;
    logic [6:0]  host_addr;
    logic [31:0] host_wdata;

    logic [31:0] Q, Q4;
    logic        host_ready, host_ready4;
    logic        host_rvalid, host_rvalid4;
    logic [31:0] host_rdata, host_rdata4;
    logic [15:0] rd_cnt, wr_cnt;
    logic [3:0]  rd_cnt4, wr_cnt4;

    data_mem_responder dut (
        .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .OEN(OEN),
        .Q(Q), .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    data_mem_responder #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .OEN(OEN),
        .Q(Q4), .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready4), .host_rvalid(host_rvalid4),
        .host_rdata(host_rdata4), .rd_cnt(rd_cnt4), .wr_cnt(wr_cnt4)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Behavioural model: plain array memory, unbounded access counts.
    logic [31:0] mem_m   [128];
    bit          known_m [128];
    logic [31:0] q_m;
    bit          q_known;
    logic [31:0] hrd_m;
    bit          hrd_known;
    bit          hrv_m;
    int          rd_m;
    int          wr_m;

    typedef struct {
        logic        cen, wen;
        logic [6:0]  a;
        logic [31:0] d;
        logic        oen, hv, hwe;
        logic [6:0]  ha;
        logic [31:0] hwd;
        logic        exp_ready;
        logic [31:0] exp_q;
        logic        exp_rv;
        logic [31:0] exp_rdata;
        int          exp_rd, exp_wr;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        q_m = 0; q_known = 1; hrd_m = 0; hrd_known = 1; hrv_m = 0; rd_m = 0; wr_m = 0;
    endtask

    // Apply the rules for one rising edge using the inputs that were held across it.
    task automatic model_edge();
        if (!rst_n) return;
        hrv_m = 0;
        if (CEN == 1'b0) begin
            if (WEN == 1'b0) begin
                mem_m[A] = D; known_m[A] = 1; wr_m++;
            end else begin
                q_m = mem_m[A]; q_known = known_m[A]; rd_m++;
            end
        end else if (host_valid) begin
            if (host_we) begin
                mem_m[host_addr] = host_wdata; known_m[host_addr] = 1;
            end else begin
                hrd_m = mem_m[host_addr]; hrd_known = known_m[host_addr]; hrv_m = 1;
            end
        end
    endtask

    task automatic compare_model();
        if (OEN || q_known) begin
            chk("q", Q, OEN ? 32'h0 : q_m);
            chk("q4", Q4, OEN ? 32'h0 : q_m);
        end
        chk("rvalid", {31'b0, host_rvalid}, {31'b0, hrv_m});
        if (hrd_known) chk("rdata", host_rdata, hrd_m);
        chk("rd_cnt", {16'b0, rd_cnt}, sat(rd_m, 65535));
        chk("wr_cnt", {16'b0, wr_cnt}, sat(wr_m, 65535));
        chk("rd_cnt4", {28'b0, rd_cnt4}, sat(rd_m, 15));
        chk("wr_cnt4", {28'b0, wr_cnt4}, sat(wr_m, 15));
    endtask

    // Driver: inputs change on the falling edge only.
    task automatic drive(input logic cen, input logic wen, input logic [6:0] a,
                         input logic [31:0] d, input logic oen, input logic hv,
                         input logic hwe, input logic [6:0] ha, input logic [31:0] hwd);
        @(negedge clk);
        CEN = cen; WEN = wen; A = a; D = d; OEN = oen;
        host_valid = hv; host_we = hwe; host_addr = ha; host_wdata = hwd;
    endtask

    // One clock: check ready before the edge, advance model, check after the edge.
    task automatic step();
        #1;
        chk("ready", {31'b0, host_ready}, {31'b0, (CEN === 1'b1)});
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic idle(input logic oen);
        drive(1'b1, 1'b1, 7'd0, 32'd0, oen, 1'b0, 1'b0, 7'd0, 32'd0);
    endtask

    function automatic vec_t mk(input logic cen, input logic wen, input logic [6:0] a,
                                input logic [31:0] d, input logic oen, input logic hv,
                                input logic hwe, input logic [6:0] ha, input logic [31:0] hwd,
                                input logic er, input logic [31:0] eq, input logic erv,
                                input logic [31:0] erd, input int ercnt, input int ewcnt);
        vec_t v;
        v.cen = cen; v.wen = wen; v.a = a; v.d = d; v.oen = oen; v.hv = hv; v.hwe = hwe;
        v.ha = ha; v.hwd = hwd; v.exp_ready = er; v.exp_q = eq; v.exp_rv = erv;
        v.exp_rdata = erd; v.exp_rd = ercnt; v.exp_wr = ewcnt;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_m[i] = 0; known_m[i] = 0;
        end
        model_reset();
        rst_n = 1'b0;
        CEN = 1; WEN = 1; A = 0; D = 0; OEN = 0;
        host_valid = 0; host_we = 0; host_addr = 0; host_wdata = 0;

        //          cen wen a      d      oen hv hwe ha     hwd      rdy q      rv rdata  rd wr
        vecs[0] = mk(1, 1, 7'd0,  32'h0, 1,  1, 1, 7'd10, 32'h13,  1, 32'h0,  0, 32'h0,  0, 0);
        vecs[1] = mk(1, 1, 7'd0,  32'h0, 1,  1, 0, 7'd10, 32'h0,   1, 32'h0,  1, 32'h13, 0, 0);
        vecs[2] = mk(1, 1, 7'd0,  32'h0, 1,  0, 0, 7'd0,  32'h0,   1, 32'h0,  0, 32'h13, 0, 0);
        vecs[3] = mk(0, 1, 7'd10, 32'h0, 0,  0, 0, 7'd0,  32'h0,   0, 32'h13, 0, 32'h13, 1, 0);
        vecs[4] = mk(1, 1, 7'd0,  32'h0, 1,  0, 0, 7'd0,  32'h0,   1, 32'h0,  0, 32'h13, 1, 0);
        vecs[5] = mk(1, 1, 7'd0,  32'h0, 0,  0, 0, 7'd0,  32'h0,   1, 32'h13, 0, 32'h13, 1, 0);
        vecs[6] = mk(0, 0, 7'd14, 32'h4, 0,  1, 0, 7'd14, 32'h0,   0, 32'h13, 0, 32'h13, 1, 1);
        vecs[7] = mk(1, 1, 7'd0,  32'h0, 0,  1, 0, 7'd14, 32'h0,   1, 32'h13, 1, 32'h4,  1, 1);
        vecs[8] = mk(0, 1, 7'd14, 32'h0, 0,  0, 0, 7'd0,  32'h0,   0, 32'h4,  0, 32'h4,  2, 1);

        // Reset state, no clock edge needed
        #1;
        chk("rst_q", Q, 32'h0);
        chk("rst_rvalid", {31'b0, host_rvalid}, 32'h0);
        chk("rst_rdata", host_rdata, 32'h0);
        chk("rst_rd_cnt", {16'b0, rd_cnt}, 32'h0);
        chk("rst_wr_cnt", {16'b0, wr_cnt}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].cen, vecs[i].wen, vecs[i].a, vecs[i].d, vecs[i].oen,
                  vecs[i].hv, vecs[i].hwe, vecs[i].ha, vecs[i].hwd);
            #1;
            chk("tbl_ready", {31'b0, host_ready}, {31'b0, vecs[i].exp_ready});
            @(posedge clk);
            model_edge();
            #1;
            chk("tbl_q", Q, vecs[i].exp_q);
            chk("tbl_rvalid", {31'b0, host_rvalid}, {31'b0, vecs[i].exp_rv});
            chk("tbl_rdata", host_rdata, vecs[i].exp_rdata);
            chk("tbl_rd_cnt", {16'b0, rd_cnt}, vecs[i].exp_rd);
            chk("tbl_wr_cnt", {16'b0, wr_cnt}, vecs[i].exp_wr);
            compare_model();
        end

        // Counter saturation on the narrow instance
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b1, 7'd10, 32'h0, 1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
            step();
        end
        chk("sat_rd4", {28'b0, rd_cnt4}, 32'hF);
        drive(1'b0, 1'b1, 7'd10, 32'h0, 1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
        step();
        chk("sat_rd4_hold", {28'b0, rd_cnt4}, 32'hF);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 7'd20, $urandom, 1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
            step();
        end
        chk("sat_wr4", {28'b0, wr_cnt4}, 32'hF);

        // Reset while a host read result is in flight
        drive(1'b1, 1'b1, 7'd0, 32'h0, 1'b0, 1'b1, 1'b0, 7'd10, 32'h0);
        step();
        chk("pre_rst_rvalid", {31'b0, host_rvalid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_rvalid", {31'b0, host_rvalid}, 32'h0);
        chk("mid_rst_rdata", host_rdata, 32'h0);
        chk("mid_rst_q", Q, 32'h0);
        chk("mid_rst_rd_cnt", {16'b0, rd_cnt}, 32'h0);
        chk("mid_rst_wr_cnt", {16'b0, wr_cnt}, 32'h0);
        // Requests presented during reset must be ignored
        drive(1'b0, 1'b0, 7'd10, 32'hDEAD, 1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
        step();
        drive(1'b1, 1'b1, 7'd0, 32'h0, 1'b0, 1'b1, 1'b1, 7'd10, 32'hBEEF);
        step();
        idle(1'b0);
        rst_n = 1'b1;
        step();
        chk("post_rst_rvalid", {31'b0, host_rvalid}, 32'h0);
        drive(1'b0, 1'b1, 7'd10, 32'h0, 1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
        step();
        chk("post_rst_q", Q, 32'h13);
        chk("post_rst_rd_cnt", {16'b0, rd_cnt}, 32'h1);

        // Random traffic on a small address window to force collisions
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), 7'($urandom_range(0, 15)),
                  $urandom, ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                  $urandom_range(0, 1), 7'($urandom_range(0, 15)), $urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
